// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: byte width and the
// 3-bit state encoding, also visible on the debug state output.
package spi_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
  localparam logic [2:0] ST_XFER      = 3'd5;
  localparam logic [2:0] ST_HOLD      = 3'd6;
  localparam logic [2:0] ST_GAP       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_SETUP     = ST_SETUP,
    S_LOAD      = ST_LOAD,
    S_START     = ST_START,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_XFER      = ST_XFER,
    S_HOLD      = ST_HOLD,
    S_GAP       = ST_GAP
  } state_t;

endpackage

// File: rtl/spi_cs_timer.sv
// Loadable down-counter with a zero flag; times the chip-select setup, hold
// and idle intervals. Counts down to zero and parks there.
module spi_cs_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transaction sequencer: owns cs_n timing, feeds the byte
// engine from the TX stream and collects received bytes into the RX stream.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_keep_cs,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              done,
  output logic              cs_n,
  output logic              spi_start,
  output logic [BYTE_W-1:0] spi_data_in,
  input  logic              spi_busy,
  input  logic [BYTE_W-1:0] spi_data_out,
  output logic [2:0]        dbg_state
);

  localparam int TMR_W = 8;

  // All streams use valid/ready: a transfer happens on the rising edge where
  // both are high; valid never depends on ready, ready may depend on valid.
  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_len, r_cnt;
  logic [LEN_W-1:0]    w_cnt_inc;
  logic                r_keep_cs;
  logic                r_cs_n, r_done, r_rx_valid;
  logic [BYTE_W-1:0]   r_rx_data, r_spi_data_in;
  logic                w_tmr_load, w_tmr_zero;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_cmd_fire, w_load_fire, w_byte_done, w_last;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == r_len);

  spi_cs_timer #(
    .W       (TMR_W),
    .RST_VAL (TMR_W'(CS_IDLE - 1))
  ) u_cs_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_GAP;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    tx_ready    = 1'b0;
    spi_start   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_cmd_fire  = 1'b0;
    w_load_fire = 1'b0;
    w_byte_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_cmd_fire = 1'b1;
          if (cmd_len != '0) begin
            // A previous keep_cs command left cs_n low: skip setup.
            if (!r_cs_n) begin
              w_state_nxt = S_LOAD;
            end else begin
              w_state_nxt = S_SETUP;
              w_tmr_load  = 1'b1;
              w_tmr_val   = TMR_W'(CS_SETUP - 1);
            end
          end
        end
      end
      S_SETUP: if (w_tmr_zero) w_state_nxt = S_LOAD;
      S_LOAD: begin
        // Holding off while rx_valid is set keeps the single RX register safe.
        if (tx_valid && !r_rx_valid && !spi_busy) begin
          tx_ready    = 1'b1;
          w_load_fire = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        spi_start   = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (spi_busy) w_state_nxt = S_XFER;
      S_XFER: begin
        if (!spi_busy) begin
          w_byte_done = 1'b1;
          if (!w_last) begin
            w_state_nxt = S_LOAD;
          end else if (r_keep_cs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMR_W'(CS_HOLD - 1);
          end
        end
      end
      S_HOLD: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(CS_IDLE - 1);
        end
      end
      S_GAP: if (w_tmr_zero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n        <= 1'b1;
      r_done        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= '0;
      r_spi_data_in <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_keep_cs     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_cmd_fire) begin
        r_len     <= cmd_len;
        r_keep_cs <= cmd_keep_cs;
        r_cnt     <= '0;
        if (cmd_len == '0) r_done <= 1'b1;
        else               r_cs_n <= 1'b0;
      end
      if (w_load_fire) r_spi_data_in <= tx_data;
      if (w_byte_done) begin
        r_rx_data  <= spi_data_out;
        r_rx_valid <= 1'b1;
        r_cnt      <= w_cnt_inc;
        if (w_last && r_keep_cs) r_done <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (r_state == S_HOLD && w_tmr_zero) begin
        r_cs_n <= 1'b1;
        r_done <= 1'b1;
      end
    end
  end

  assign cs_n        = r_cs_n;
  assign done        = r_done;
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign spi_data_in = r_spi_data_in;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl with a loopback byte-engine model: stimulus pushes
// expected bytes into queues, a negedge monitor pops and compares.
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  localparam int LEN_W    = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;
  localparam int ENG_LAT  = 4;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready, cmd_keep_cs;
  logic [LEN_W-1:0] cmd_len;
  logic             tx_valid, tx_ready;
  logic [7:0]       tx_data;
  logic             rx_valid, rx_ready;
  logic [7:0]       rx_data;
  logic             done, cs_n, spi_start, spi_busy;
  logic [7:0]       spi_data_in, spi_data_out;
  logic [2:0]       dbg_state;

  spi_xfer_ctrl #(
    .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_keep_cs(cmd_keep_cs),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done), .cs_n(cs_n), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_busy(spi_busy),
    .spi_data_out(spi_data_out), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // loopback byte engine: busy for ENG_LAT cycles, returns the byte it was sent
  logic [3:0] eng_cnt;
  logic [7:0] eng_sh;
  always @(posedge clk) begin
    if (rst) begin
      spi_busy     <= 1'b0;
      eng_cnt      <= 4'd0;
      eng_sh       <= 8'h00;
      spi_data_out <= 8'h00;
    end else if (spi_start && !spi_busy) begin
      spi_busy <= 1'b1;
      eng_cnt  <= 4'(ENG_LAT - 1);
      eng_sh   <= spi_data_in;
    end else if (spi_busy) begin
      if (eng_cnt == 4'd0) begin
        spi_busy     <= 1'b0;
        spi_data_out <= eng_sh;
      end else begin
        eng_cnt <= eng_cnt - 4'd1;
      end
    end
  end

  // scoreboard state
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] tx_src_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: event times in negedge counts
  int  ncyc = 0;
  int  n_start = 0, n_done = 0, n_txhs = 0, n_cs_rise = 0, n_cs_fall = 0, n_cs_high = 0;
  int  t_start = 0, t_done = 0, t_acc = 0, t_cs_rise = 0, t_cs_fall = 0, t_busy_fall = 0;
  int  t_ready = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0, prev_ready = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst) begin
        if (prev_cs && !cs_n) begin t_cs_fall = ncyc; n_cs_fall++; end
        if (!prev_cs && cs_n) begin t_cs_rise = ncyc; n_cs_rise++; end
        if (prev_busy && !spi_busy) t_busy_fall = ncyc;
        if (!prev_ready && cmd_ready) t_ready = ncyc;
        if (cs_n) n_cs_high++;
        if (spi_start) begin
          n_start++;
          t_start = ncyc;
          check("start_cs_low", int'(cs_n), 0);
          if (exp_tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spi_data_in: unexpected start with %0h", spi_data_in);
          end else begin
            check("spi_data_in", int'(spi_data_in), int'(exp_tx_q.pop_front()));
          end
        end
        if (done) begin n_done++; t_done = ncyc; end
        if (cmd_valid && cmd_ready) t_acc = ncyc;
        if (tx_valid && tx_ready) n_txhs++;
        if (rx_valid && rx_ready) begin
          if (exp_rx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_data: unexpected byte %0h", rx_data);
          end else begin
            check("rx_data", int'(rx_data), int'(exp_rx_q.pop_front()));
          end
        end
      end
      prev_cs    = cs_n;
      prev_busy  = spi_busy;
      prev_ready = cmd_ready;
    end
  end

  // TX source driver: presents the head of tx_src_q, pops on handshake
  initial begin
    logic hs;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs = tx_valid && tx_ready;
      @(posedge clk);
      #1;
      if (hs && tx_src_q.size() > 0) void'(tx_src_q.pop_front());
      tx_valid = (tx_src_q.size() > 0);
      if (tx_valid) tx_data = tx_src_q[0];
      else          tx_data = 8'h00;
    end
  end

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    tx_src_q.push_back(b);
    exp_tx_q.push_back(b);
    exp_rx_q.push_back(b);
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic keep);
    logic ok;
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_len     = len;
    cmd_keep_cs = keep;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accepted", int'(ok), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    base = n_done;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_done > base) break;
    end
    check(name, int'(n_done > base), 1);
  endtask

  int base_start, base_done, base_txhs, base_rise, base_fall, base_high, lows;
  logic found;

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_len     = '0;
    cmd_keep_cs = 1'b0;
    rx_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_tx_ready", int'(tx_ready), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_spi_start", int'(spi_start), 0);
    check("rst_spi_data_in", int'(spi_data_in), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
      lows++;
    end
    check("reset_idle_gap", lows, CS_IDLE);

    // single byte, full cs timing
    base_start = n_start;
    push_byte(8'hA5);
    send_cmd(8'd1, 1'b0);
    wait_done("t1_done", 200);
    repeat (6) @(posedge clk);
    check("t1_cs_fall_after_accept", t_cs_fall - t_acc, 1);
    check("t1_setup", t_start - t_cs_fall, CS_SETUP + 1);
    check("t1_hold", t_cs_rise - t_busy_fall, CS_HOLD + 1);
    check("t1_done_with_cs_rise", t_done, t_cs_rise);
    check("t1_idle_gap", t_ready - t_cs_rise, CS_IDLE);
    check("t1_starts", n_start - base_start, 1);

    // len=4 with RX backpressure after first byte
    base_start = n_start; base_txhs = n_txhs; base_rise = n_cs_rise;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    send_cmd(8'd4, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t2_stall_starts", n_start - base_start, 1);
    check("t2_stall_txhs", n_txhs - base_txhs, 1);
    check("t2_stall_cs_low", int'(cs_n), 0);
    check("t2_stall_rx_valid", int'(rx_valid), 1);
    check("t2_stall_no_rise", n_cs_rise - base_rise, 0);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    wait_done("t2_done", 400);
    check("t2_starts", n_start - base_start, 4);
    check("t2_txhs", n_txhs - base_txhs, 4);
    check("t2_rx_drained", exp_rx_q.size(), 0);

    // TX starvation mid-transaction
    base_start = n_start;
    push_byte(8'h3C);
    send_cmd(8'd3, 1'b0);
    repeat (20) @(posedge clk);
    base_high = n_cs_high;
    base_done = n_start;
    repeat (20) @(posedge clk);
    check("t3_no_start_starved", n_start - base_done, 0);
    check("t3_cs_low_starved", n_cs_high - base_high, 0);
    push_byte(8'h5A);
    push_byte(8'hC3);
    wait_done("t3_done", 400);
    check("t3_starts", n_start - base_start, 3);
    check("t3_rx_drained", exp_rx_q.size(), 0);

    // keep_cs chaining
    base_done = n_done; base_rise = n_cs_rise; base_fall = n_cs_fall;
    push_byte(8'h11);
    push_byte(8'h22);
    send_cmd(8'd2, 1'b1);
    wait_done("t4_done1", 300);
    @(negedge clk);
    check("t4_cs_held", int'(cs_n), 0);
    push_byte(8'h33);
    send_cmd(8'd1, 1'b0);
    wait_done("t4_done2", 300);
    check("t4_skip_setup", t_start - t_acc, 2);
    check("t4_single_rise", n_cs_rise - base_rise, 1);
    check("t4_single_fall", n_cs_fall - base_fall, 1);
    check("t4_two_dones", n_done - base_done, 2);

    // zero-length command
    base_start = n_start; base_fall = n_cs_fall;
    send_cmd(8'd0, 1'b0);
    wait_done("t5_done", 20);
    check("t5_done_latency", t_done - t_acc, 1);
    @(negedge clk);
    check("t5_done_pulse", int'(done), 0);
    check("t5_cs_high", int'(cs_n), 1);
    check("t5_no_start", n_start - base_start, 0);
    check("t5_no_cs_fall", n_cs_fall - base_fall, 0);

    // reset during XFER of byte 2 of 4
    base_start = n_start;
    for (int i = 0; i < 4; i++) push_byte(8'h81 + 8'(i));
    send_cmd(8'd4, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (n_start - base_start >= 2 && dbg_state == ST_XFER) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_xfer2", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_rst_cs_n", int'(cs_n), 1);
    check("t6_rst_rx_valid", int'(rx_valid), 0);
    check("t6_rst_done", int'(done), 0);
    exp_rx_q.delete();
    exp_tx_q.delete();
    tx_src_q.delete();
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    base_start = n_start;
    push_byte(8'h99);
    send_cmd(8'd1, 1'b0);
    wait_done("t6_post_done", 200);
    check("t6_post_starts", n_start - base_start, 1);

    repeat (5) @(posedge clk);
    check("end_rx_drained", exp_rx_q.size(), 0);
    check("end_tx_drained", exp_tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
